// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_tx shared types: FSM state encoding and line constants.
// Optional parity frame bit is enabled by FIFO_UART_TX_PARITY_EN.
package fifo_uart_tx_pkg;

  localparam int   DATA_W     = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// baud_tick_gen: bit-period counter for fifo_uart_tx.
// Emits a one-cycle tick on the last cycle of every bit period.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = ~clr & (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a byte FIFO and sends them as UART frames.
// Define FIFO_UART_TX_PARITY_EN to append an even-parity bit after DATA.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_en,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_data,
  output logic             fifo_r_en,
  output logic             tx_line,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam logic [2:0] LAST_DATA = 3'(DATA_W - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  state_t            state;
  state_t            state_n;
  logic              tick;
  logic              baud_clr;
  logic [DATA_W-1:0] data_q;
  logic [2:0]        bit_cnt;

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .clr (baud_clr),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (fifo_r_en) state_n = WAIT;
      WAIT:   state_n = START;
      START:  if (tick) state_n = DATA;
      DATA: begin
        if (tick && bit_cnt == LAST_DATA) begin
`ifdef FIFO_UART_TX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end
      end
      PARITY: if (tick) state_n = STOP;
      STOP: begin
        if (tick && bit_cnt == LAST_STOP) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Pop is gated by reset too so no byte is consumed while held in reset.
  always_comb begin
    fifo_r_en = 1'b0;
    busy      = 1'b1;
    baud_clr  = 1'b0;
    unique case (state)
      IDLE: begin
        fifo_r_en = tx_en & ~fifo_empty & ~rst;
        busy      = 1'b0;
        baud_clr  = 1'b1;
      end
      WAIT:    baud_clr = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_line   <= IDLE_LEVEL;
      data_q    <= '0;
      bit_cnt   <= '0;
      frame_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: tx_line <= IDLE_LEVEL;
        WAIT: begin
          data_q  <= fifo_data;
          tx_line <= ~IDLE_LEVEL;
          bit_cnt <= '0;
        end
        START: begin
          if (tick) begin
            tx_line <= data_q[0];
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
              tx_line <= ^data_q;
`else
              tx_line <= IDLE_LEVEL;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx_line <= data_q[bit_cnt + 3'd1];
            end
          end
        end
        PARITY: begin
          if (tick) begin
            tx_line <= IDLE_LEVEL;
            bit_cnt <= '0;
          end
        end
        STOP: begin
          if (tick) begin
            if (bit_cnt == LAST_STOP) begin
              bit_cnt   <= '0;
              frame_cnt <= frame_cnt + 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        default: tx_line <= IDLE_LEVEL;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: behavioural FIFO, line-level frame
// decoder and random plus directed stimulus.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int SB  = 1;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB = 9 + P + SB;
  localparam int FL = NB * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_en = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_r_en;
  logic        tx_line;
  logic        busy;
  logic [15:0] frame_cnt;

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (SB),
    .CNT_W       (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_en     (tx_en),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_r_en (fifo_r_en),
    .tx_line   (tx_line),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int          nchk = 0;
  int          nfail = 0;
  int          cyc = 0;
  logic [15:0] exp_frames = '0;
  logic [7:0]  wq[$];
  logic [7:0]  fq[$];
  logic [7:0]  exp_q[$];
  int          starts[$];
  logic        prev_ren = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic wr(input logic [7:0] b);
    wq.push_back(b);
    exp_q.push_back(b);
  endtask

  // Byte FIFO model: data appears the cycle after a pop.
  always @(posedge clk) begin
    cyc++;
    if (fifo_r_en && fq.size() > 0) fifo_data <= fq.pop_front();
    while (wq.size() > 0) fq.push_back(wq.pop_front());
    fifo_empty <= (fq.size() == 0);
  end

  always @(negedge clk) begin
    if (fifo_r_en) begin
      chk("r_en_legal", {fifo_empty, busy, prev_ren, ~tx_en}, 32'h0);
    end
    prev_ren = fifo_r_en;
  end

  // Frame decoder: every sample of a bit must match its first sample.
  initial begin : mon
    logic [NB-1:0] bits;
    logic [7:0]    got;
    logic [7:0]    exp;
    bit            ab;
    forever begin
      @(negedge clk);
      if (rst || tx_line !== 1'b0) continue;
      starts.push_back(cyc);
      ab = 1'b0;
      bits = '0;
      for (int b = 0; b < NB; b++) begin
        for (int s = 0; s < CPB; s++) begin
          if (b != 0 || s != 0) @(negedge clk);
          if (rst) begin
            ab = 1'b1;
            break;
          end
          if (s == 0) bits[b] = tx_line;
          else chk("bit_hold", 32'(tx_line), 32'(bits[b]));
        end
        if (ab) break;
      end
      if (ab) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        continue;
      end
      got = bits[8:1];
      chk("stop_bit", 32'(bits[NB-1]), 32'h1);
`ifdef FIFO_UART_TX_PARITY_EN
      chk("parity_bit", 32'(bits[9]), 32'(^got));
`endif
      if (exp_q.size() == 0) begin
        chk("unexpected_frame", 32'(got), 32'hFFFF_FFFF);
      end else begin
        exp = exp_q.pop_front();
        chk("frame_byte", 32'(got), 32'(exp));
      end
      @(posedge clk);
      @(negedge clk);
      if (!rst) begin
        exp_frames = exp_frames + 16'd1;
        chk("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n >= budget), 32'h0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_fall(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx_line !== 1'b0 && n < budget);
    chk("start_timeout", 32'(n >= budget), 32'h0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_line", 32'(tx_line), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_r_en", 32'(fifo_r_en), 32'h0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // single frame
    wr(8'hA1);
    tx_en = 1'b1;
    wait_idle(200);
    chk("one_frame_cnt", 32'(frame_cnt), 32'd1);

    // back-to-back frames with 2-cycle gaps
    starts.delete();
    @(posedge clk);
    #1;
    wr(8'hA1);
    wr(8'hB2);
    wr(8'hC3);
    wait_idle(400);
    chk("b2b_frames", 32'(starts.size()), 32'd3);
    if (starts.size() == 3) begin
      chk("gap_0", 32'(starts[1] - starts[0]), 32'(FL + 2));
      chk("gap_1", 32'(starts[2] - starts[1]), 32'(FL + 2));
    end
    chk("b2b_cnt", 32'(frame_cnt), 32'd4);
    chk("b2b_empty", 32'(fifo_empty), 32'h1);

    // empty FIFO stays quiet
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("empty_quiet", {30'd0, fifo_r_en, tx_line}, 32'h1);
    end

    // tx_en dropped during data bit 2
    @(posedge clk);
    #1;
    wr(8'h3C);
    wr(8'hB2);
    wait_fall(50);
    repeat (13) @(posedge clk);
    #1 tx_en = 1'b0;
    repeat (60) @(posedge clk);
    @(negedge clk);
    chk("hold_cnt", 32'(frame_cnt), 32'd5);
    chk("hold_not_empty", 32'(fifo_empty), 32'h0);
    chk("hold_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1 tx_en = 1'b1;
    wait_idle(200);
    chk("resume_cnt", 32'(frame_cnt), 32'd6);

    // reset during data bit 3 drops the frame
    @(posedge clk);
    #1 wr(8'h5A);
    wait_fall(50);
    repeat (17) @(posedge clk);
    #1 rst = 1'b1;
    exp_frames = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_tx_line", 32'(tx_line), 32'h1);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_cnt", 32'(frame_cnt), 32'h0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      chk("abort_quiet", {31'd0, tx_line}, 32'h1);
    end
    chk("abort_dropped", 32'(exp_q.size()), 32'h0);

    // random writes with tx_en toggling
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(3) == 0) wr(8'($urandom));
      if ($urandom_range(24) == 0) tx_en = ~tx_en;
    end
    tx_en = 1'b1;
    wait_idle(8000);
    chk("final_cnt", 32'(frame_cnt), 32'(exp_frames));
    chk("final_empty", 32'(fifo_empty), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule
